// File: rtl/diferential_muxpga_array.sv
// rtl/diferential_muxpga_array.sv - mux-FPGA fabric: serial nibble config chain, ALU cells, readback window, RUN mode
module diferential_muxpga_array #(
    parameter int ROWS = 5,
    parameter int COLS = 3,
    parameter int B    = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     cmd,
    input  logic [B-1:0]   din,
    output logic [2*B-1:0] dout,
    output logic           busy
);

    localparam int NCELL = (ROWS - 1) * COLS;
    localparam int NCFG  = 2 * NCELL;
    localparam int PW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam logic [31:0] NCELL_U = NCELL;

    typedef enum logic [1:0] {
        CMD_CFG_SHIFT = 2'd0,
        CMD_STEP      = 2'd1,
        CMD_SELECT    = 2'd2,
        CMD_RUN       = 2'd3
    } cmd_e;

    logic [3:0]     r_cfg [NCFG];
    logic [B-1:0]   r_q   [NCELL];
    logic [B-1:0]   w_res [NCELL];
    logic [PW-1:0]  r_rb_ptr;
    logic [PW-1:0]  w_rb_nxt;
    logic [B-1:0]   r_rcnt;
    logic [2*B-1:0] w_tail;
    cmd_e           w_cmd;

    function automatic logic [B-1:0] f_sel(input logic [1:0] s, input logic [B-1:0] n,
                                           input logic [B-1:0] so, input logic [B-1:0] w,
                                           input logic [B-1:0] e);
        case (s)
            2'd0:    return n;
            2'd1:    return so;
            2'd2:    return w;
            default: return e;
        endcase
    endfunction

    function automatic logic [B-1:0] f_alu(input logic [3:0] op, input logic [B-1:0] a,
                                           input logic [B-1:0] b, input logic [B-1:0] cur);
        case (op)
            4'd0:    return a | b;
            4'd1:    return a & b;
            4'd2:    return a;
            4'd3:    return b;
            4'd4:    return a ^ b;
            4'd5:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ~a;
            4'd8:    return {a[B-2:0], a[B-1]};
            4'd9:    return a >> 1;
            4'd10:   return ~(a & b);
            4'd11:   return {B{a == b}};
            default: return cur;
        endcase
    endfunction

    // Each cell sees only pre-step q values, so all cells update in lockstep.
    for (genvar r = 1; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int K  = (r - 1) * COLS + c;
            localparam int KW = (r - 1) * COLS + (c + COLS - 1) % COLS;
            localparam int KE = (r - 1) * COLS + (c + 1) % COLS;
            logic [B-1:0] w_n;
            logic [B-1:0] w_s;
            logic [B-1:0] w_in1;
            logic [B-1:0] w_in2;

            if (r == 1) begin : g_n_din
                assign w_n = din;
            end else begin : g_n_cell
                assign w_n = r_q[K-COLS];
            end

            if (r == ROWS - 1) begin : g_s_din
                assign w_s = din;
            end else begin : g_s_cell
                assign w_s = r_q[K+COLS];
            end

            assign w_in1    = f_sel(r_cfg[2*K][1:0], w_n, w_s, r_q[KW], r_q[KE]);
            assign w_in2    = f_sel(r_cfg[2*K][3:2], w_n, w_s, r_q[KW], r_q[KE]);
            assign w_res[K] = f_alu(r_cfg[2*K+1], w_in1, w_in2, r_q[K]);
        end
    end

    assign w_cmd = cmd_e'(cmd);
    assign busy  = (r_rcnt != '0);

    always_comb begin
        w_rb_nxt = (r_rb_ptr == PW'(NCELL - 1)) ? '0 : r_rb_ptr + PW'(1);
        w_tail = '0;
        w_tail[B+3:B] = r_cfg[NCFG-1];
        if (busy || w_cmd != CMD_CFG_SHIFT) begin
            dout = {r_q[r_rb_ptr], r_q[w_rb_nxt]};
        end else begin
            dout = w_tail;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg    <= '{default: '0};
            r_q      <= '{default: '0};
            r_rb_ptr <= '0;
            r_rcnt   <= '0;
        end else if (busy) begin
            r_q    <= w_res;
            r_rcnt <= r_rcnt - B'(1);
        end else begin
            case (w_cmd)
                CMD_CFG_SHIFT: begin
                    for (int i = NCFG - 1; i > 0; i--) begin
                        r_cfg[i] <= r_cfg[i-1];
                    end
                    r_cfg[0] <= din[3:0];
                end
                CMD_STEP: r_q <= w_res;
                CMD_SELECT: begin
                    if (32'(din) < NCELL_U) begin
                        r_rb_ptr <= din[PW-1:0];
                    end
                end
                default: r_rcnt <= din;
            endcase
        end
    end

endmodule
